// File: rtl/dct_1d_stream.sv
// dct_1d_stream: 8-point 1-D forward DCT engine with valid/ready streaming,
// block-end sideband and a fully stallable 4-stage pipeline.
//   S1 input register -> S2 even/odd butterflies -> S3 constant multiplies
//   -> S4 adder tree + output format (output register).
// Optional feature macro: DCT1D_ROUND_EN
//   defined   : X_k = (A_k + 2^(F-1)) >>> F, W = N+3
//   undefined : X_k = A_k (F fraction bits kept), W = N+F+3
module dct_1d_stream #(
  parameter int N = 8,
  parameter int F = 12,
`ifdef DCT1D_ROUND_EN
  localparam int W = N + 3
`else
  localparam int W = N + F + 3
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_last,
  input  logic [8*N-1:0] x_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [8*W-1:0] X_out
);

  localparam int SW = N + 1;      // butterfly sum/difference width
  localparam int PW = N + F + 2;  // product width
  localparam int AW = N + F + 3;  // accumulator width, holds the exact sum
  localparam int FW = F + 1;      // coefficient width

  // Elaboration-time coefficient C[k][n] for n = 0..3. The other half of each
  // row follows from symmetry: even rows mirror, odd rows mirror negated,
  // which is what lets the butterflies feed four multiplies per output.
  function automatic int coef_val(input int k, input int n);
    int  m;
    int  mag;
    bit  neg;
    real h;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    neg = 1'b0;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    // h = 0.5 * cos(m*pi/16)
    case (m)
      0:       h = 0.5;
      1:       h = 0.49039264020161522;
      2:       h = 0.46193976625564337;
      3:       h = 0.41573480615127262;
      4:       h = 0.35355339059327376;
      5:       h = 0.27778511650980114;
      6:       h = 0.19134171618254492;
      7:       h = 0.09754516100806417;
      default: h = 0.0;
    endcase
    if (k == 0) h = 0.35355339059327376;  // 0.5 * (1/sqrt(2))
    // No value is an exact tie, so +0.5 and truncate is round-half-away.
    mag = $rtoi(h * real'(1 << F) + 0.5);
    return neg ? -mag : mag;
  endfunction

  logic signed [FW-1:0] coef [8][4];

  for (genvar k = 0; k < 8; k++) begin : g_coef_k
    for (genvar n = 0; n < 4; n++) begin : g_coef_n
      localparam int CV = coef_val(k, n);
      assign coef[k][n] = FW'(CV);
    end
  end

  // Pipeline state
  logic                 en;
  logic                 v1, v2, v3;
  logic                 l1, l2, l3;
  logic signed [N-1:0]  x_r [8];
  logic signed [SW-1:0] s_r [4];
  logic signed [SW-1:0] d_r [4];
  logic signed [PW-1:0] p_r [8][4];
  logic signed [AW-1:0] acc [8];
  logic [8*W-1:0]       x_fmt;

  // One global enable: the whole pipe advances unless a valid output is
  // being held for a stalled consumer.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Valid/last shift chain, the only pipeline control state.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its neighbour; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
      l3 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      l1 <= in_last;
      v2 <= v1;
      l2 <= l1;
      v3 <= v2;
      l3 <= l2;
    end
  end

  // S1: capture the input samples.
  // NOTE: datapath registers carry no reset; they are qualified by the valid
  // chain and the output register zeroes anything invalid.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) x_r[i] <= x_in[i*N +: N];
    end
  end

  // S2: even/odd butterflies.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int n = 0; n < 4; n++) begin
        s_r[n] <= SW'(x_r[n]) + SW'(x_r[7-n]);
        d_r[n] <= SW'(x_r[n]) - SW'(x_r[7-n]);
      end
    end
  end

  // S3: constant multiplies; even rows use sums, odd rows use differences.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 8; k++) begin
        for (int n = 0; n < 4; n++) begin
          p_r[k][n] <= PW'(coef[k][n]) * PW'((k % 2 == 0) ? s_r[n] : d_r[n]);
        end
      end
    end
  end

`ifdef DCT1D_ROUND_EN
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (F - 1));
`endif

  // S4 combinational part: exact adder tree and output format.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    x_fmt = '0;
    for (int k = 0; k < 8; k++) acc[k] = '0;
    for (int k = 0; k < 8; k++) begin
      acc[k] = AW'(p_r[k][0]) + AW'(p_r[k][1]) + AW'(p_r[k][2]) + AW'(p_r[k][3]);
`ifdef DCT1D_ROUND_EN
      x_fmt[k*W +: W] = W'((acc[k] + HALF) >>> F);
`else
      x_fmt[k*W +: W] = acc[k];
`endif
    end
  end

  // S4 output register: zero data and last on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      X_out     <= '0;
    end else if (en) begin
      out_valid <= v3;
      out_last  <= v3 && l3;
      X_out     <= v3 ? x_fmt : '0;
    end
  end

endmodule

// File: tb/tb_dct_1d_stream.sv
// tb_dct_1d_stream: directed table vectors plus streaming, backpressure,
// bubble and mid-stream reset sequences, checked against a direct-sum model.
module tb_dct_1d_stream;

  localparam int N = 8;
  localparam int F = 12;
`ifdef DCT1D_ROUND_EN
  localparam int W = N + 3;
`else
  localparam int W = N + F + 3;
`endif
  localparam real PI = 3.14159265358979323846;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_last   = 1'b0;
  logic           out_ready = 1'b0;
  logic [8*N-1:0] x_in      = '0;
  logic           in_ready;
  logic           out_valid;
  logic           out_last;
  logic [8*W-1:0] X_out;

  dct_1d_stream #(.N(N), .F(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .X_out     (X_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][63:0] a;
    logic             last;
    logic [31:0]      cyc;
  } exp_t;

  typedef struct packed {
    logic [8*N-1:0]   x;
    logic [7:0][63:0] e;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   coef [8][8];
  exp_t sb [$];
  int   cyc          = 0;
  bit   lat_chk      = 1'b0;
  bit   rand_rdy     = 1'b0;
  int   n_out        = 0;
  int   stall_cycles = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint xf(input logic [8*W-1:0] v, input int k);
    logic signed [W-1:0] t;
    t = v[k*W +: W];
    return longint'(t);
  endfunction

  function automatic logic [7:0][63:0] mk(input longint e0, e1, e2, e3,
                                          input longint e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // Direct 8x8 sum, no butterflies.
  function automatic exp_t model(input logic [8*N-1:0] v, input logic last, input int c);
    exp_t                e;
    longint              acc;
    logic signed [N-1:0] xs;
    e      = '0;
    e.last = last;
    e.cyc  = c;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        xs  = v[n*N +: N];
        acc = acc + longint'(xs) * longint'(coef[k][n]);
      end
`ifdef DCT1D_ROUND_EN
      acc = (acc + (longint'(1) <<< (F - 1))) >>> F;
`endif
      e.a[k] = acc;
    end
    return e;
  endfunction

  function automatic bit fits(input exp_t e);
    longint lo;
    longint hi;
    bit     ok;
    lo = -(longint'(1) <<< (W - 1));
    hi = (longint'(1) <<< (W - 1)) - 1;
    ok = 1'b1;
    for (int k = 0; k < 8; k++)
      if ($signed(e.a[k]) < lo || $signed(e.a[k]) > hi) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [8*N-1:0] rand_vec();
    logic [8*N-1:0] v;
    for (int j = 0; j < 8; j++) v[j*N +: N] = N'($urandom);
    return v;
  endfunction

  // Inputs change at posedge+2; this monitor samples at the negedge, so
  // every handshake it sees is the one the next rising edge will take.
  initial begin : monitor
    exp_t           e;
    logic [8*W-1:0] prev_x;
    logic           prev_last;
    bit             prev_stall;
    prev_x     = '0;
    prev_last  = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", longint'(out_valid), 1);
          check("stall_X_stable", longint'(X_out == prev_x), 1);
          check("stall_last_stable", longint'(out_last), longint'(prev_last));
        end
        if (out_valid && !out_ready) begin
          stall_cycles++;
          check("stall_in_ready_low", longint'(in_ready), 0);
        end
        if (!out_valid) begin
          check("idle_X_zero", longint'(X_out == '0), 1);
          check("idle_last_zero", longint'(out_last), 0);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", longint'(sb.size()), 1);
          end else begin
            e = sb.pop_front();
            for (int k = 0; k < 8; k++)
              check($sformatf("out%0d_X%0d", n_out, k), xf(X_out, k), $signed(e.a[k]));
            check($sformatf("out%0d_last", n_out), longint'(out_last), longint'(e.last));
            if (lat_chk) check($sformatf("out%0d_latency", n_out), longint'(cyc - int'(e.cyc)), 4);
            n_out++;
          end
        end
        if (in_valid && in_ready) begin
          e = model(x_in, in_last, cyc);
          check("no_overflow", longint'(fits(e)), 1);
          sb.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_x     = X_out;
        prev_last  = out_last;
      end
    end
  end

  // Random backpressure for the bubble sequence.
  initial begin : rand_ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+2; returns at posedge+2 right after the accepting edge.
  task automatic send(input logic [8*N-1:0] v, input logic last);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    x_in     = v;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (budget >= 200) check("in_ready_timeout", longint'(in_ready), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts negedges until out_valid, bounded.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || out_valid) && b < 300) begin
      @(posedge clk);
      #2;
      b++;
    end
    check("drain_done", longint'(sb.size()), 0);
  endtask

  initial begin : main
    vec_t tbl [4];
    real  v;
    real  ck;
    int   lat;

    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      for (int n = 0; n < 8; n++) begin
        v = 0.5 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0) * real'(1 << F);
        coef[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      end
    end

    // Directed vectors: DC max, DC min, impulse at x0, x0=10 / x7=-10.
    tbl[0].x = {8{8'h7F}};
    tbl[1].x = {8{8'h80}};
    tbl[2].x = {56'h0, 8'd100};
    tbl[3].x = {8'hF6, 48'h0, 8'h0A};
`ifdef DCT1D_ROUND_EN
    tbl[0].e = mk(359, 0, 0, 0, 0, 0, 0, 0);
    tbl[1].e = mk(-362, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].e = mk(35, 49, 46, 42, 35, 28, 19, 10);
    tbl[3].e = mk(0, 10, 0, 8, 0, 6, 0, 2);
`else
    tbl[0].e = mk(1471168, 0, 0, 0, 0, 0, 0, 0);
    tbl[1].e = mk(-1482752, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].e = mk(144800, 200900, 189200, 170300, 144800, 113800, 78400, 40000);
    tbl[3].e = mk(0, 40180, 0, 34060, 0, 22760, 0, 8000);
`endif

    // Reset state.
    #12;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_X_zero", longint'(X_out == '0), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    check("post_rst_in_ready", longint'(in_ready), 1);

    // Table vectors, one at a time.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].x, 1'b0);
      wait_out(lat);
      check($sformatf("tbl%0d_latency", i), longint'(lat), 4);
      for (int k = 0; k < 8; k++)
        check($sformatf("tbl%0d_X%0d", i, k), xf(X_out, k), $signed(tbl[i].e[k]));
      @(posedge clk);
      #2;
    end
    drain();

    // 64 back-to-back random vectors, last on every 8th.
    n_out = 0;
    for (int i = 0; i < 64; i++) send(rand_vec(), 1'((i % 8) == 7));
    drain();
    check("stream_count", longint'(n_out), 64);

    // Backpressure: 10-cycle stall mid-stream.
    lat_chk      = 1'b0;
    n_out        = 0;
    stall_cycles = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(rand_vec(), 1'((i % 8) == 7));
      end
      begin
        repeat (6) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        repeat (10) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", longint'(n_out), 16);
    check("bp_stall_cycles", longint'(stall_cycles), 10);

    // Bubbles: in_valid 1,0,0 pattern with random out_ready.
    n_out    = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(rand_vec(), 1'(i == 11));
      idle(2);
    end
    rand_rdy = 1'b0;
    idle(1);
    out_ready = 1'b1;
    drain();
    check("bubble_count", longint'(n_out), 12);

    // Reset with three vectors in flight.
    for (int i = 0; i < 3; i++) send(rand_vec(), 1'b0);
    idle(1);
    check("mid_rst_pre_valid", longint'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_X_zero", longint'(X_out == '0), 1);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    n_out = 0;
    idle(3);
    check("mid_rst_quiet", longint'(out_valid), 0);
    send(rand_vec(), 1'b1);
    wait_out(lat);
    check("mid_rst_latency", longint'(lat), 4);
    @(posedge clk);
    #2;
    drain();
    check("mid_rst_count", longint'(n_out), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
